// File: rtl/harq_soft_combine_engine.sv
// Purpose: HARQ soft combiner that fills, then saturating-accumulates, LLR rows into a ping/pong buffer.
// Latency: a row written the cycle after its input beat; o_done one cycle after i_harq_ack.
// Backpressure: o_llr_ready high in FILL/COMBINE only; 1 row/cycle sustained with no bubbles.
// Ports: i_core_clk/i_rx_rstn clock and async active-low reset; i_fsm_clr sync abort;
//   i_start/i_user_index/i_users_ncb/i_buf_sel job start; i_llr_* input row stream;
//   o_ram_* / i_ram_rd_data combine-buffer access (1-cycle read latency);
//   o_harq_req/o_harq_buf/o_harq_rows/i_harq_ack send handoff; o_done/o_err/o_busy status.
module harq_soft_combine_engine #(
  parameter int LANES     = 16,
  parameter int LLR_W     = 6,
  parameter int ACC_W     = 10,
  parameter int ADDR_W    = 11,
  parameter int NUM_USERS = 8,
  parameter int NCB_W     = 16
) (
  input  logic                           i_core_clk,
  input  logic                           i_rx_rstn,
  input  logic                           i_fsm_clr,
  input  logic                           i_start,
  input  logic [$clog2(NUM_USERS)-1:0]   i_user_index,
  input  logic [NUM_USERS*NCB_W-1:0]     i_users_ncb,
  input  logic                           i_buf_sel,
  input  logic                           i_llr_valid,
  output logic                           o_llr_ready,
  input  logic [LANES*LLR_W-1:0]         i_llr_data,
  input  logic                           i_llr_last,
  output logic [ADDR_W-1:0]              o_ram_rd_addr,
  output logic                           o_ram_rd_sel,
  input  logic [LANES*ACC_W-1:0]         i_ram_rd_data,
  output logic                           o_ram_wr_en,
  output logic                           o_ram_wr_sel,
  output logic [ADDR_W-1:0]              o_ram_wr_addr,
  output logic [LANES*ACC_W-1:0]         o_ram_wr_data,
  output logic                           o_harq_req,
  output logic                           o_harq_buf,
  output logic [ADDR_W:0]                o_harq_rows,
  input  logic                           i_harq_ack,
  output logic                           o_done,
  output logic                           o_err,
  output logic                           o_busy
);

  localparam int RW     = ADDR_W + 1;
  localparam int LG_LNS = $clog2(LANES);
  localparam logic signed [LLR_W-1:0] LLR_MIN  = {1'b1, {(LLR_W-1){1'b0}}};
  localparam logic signed [LLR_W-1:0] LLR_NMAX = LLR_MIN + LLR_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = -ACC_MAX;
  localparam logic signed [ACC_W:0]   SUM_MAX  = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   SUM_MIN  = -SUM_MAX;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_COMBINE, S_FLUSH, S_HANDOFF} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        ptr_q, ptr_d;
  logic [RW-1:0]            rows_q, rows_d;
  logic                     buf_q, buf_d;
  logic                     done_q, done_d, err_q, err_d;
  // Write stage: one pending row write per input beat, issued the following cycle.
  logic                     p_vld_q, p_vld_d, p_cmb_q, p_cmb_d, p_fwd_q, p_fwd_d;
  logic [ADDR_W-1:0]        p_addr_q, p_addr_d;
  logic [LANES*ACC_W-1:0]   p_llr_q, p_llr_d, p_fwd_dat_q, p_fwd_dat_d;

  logic [NCB_W-1:0]         ncb_sel;
  logic [NCB_W:0]           r_calc;
  logic                     r_bad, ptr_wrap, beat;
  logic [LANES*ACC_W-1:0]   llr_ext, wr_dat;

  assign ncb_sel  = i_users_ncb[i_user_index*NCB_W +: NCB_W];
  assign r_calc   = ({1'b0, ncb_sel} + (NCB_W+1)'(LANES-1)) >> LG_LNS;
  assign r_bad    = (r_calc == '0) || (32'(r_calc) > (32'd1 << ADDR_W));
  assign ptr_wrap = ({1'b0, ptr_q} == rows_q - RW'(1));
  assign beat     = i_llr_valid && o_llr_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [LLR_W-1:0] llr_in, llr_c;
    logic signed [ACC_W-1:0] p_llr, opnd;
    logic signed [ACC_W:0]   sum;
    assign llr_in = i_llr_data[k*LLR_W +: LLR_W];
    // Most-negative LLR folded in so the input range is symmetric.
    assign llr_c  = (llr_in == LLR_MIN) ? LLR_NMAX : llr_in;
    assign llr_ext[k*ACC_W +: ACC_W] = {{(ACC_W-LLR_W){llr_c[LLR_W-1]}}, llr_c};
    assign p_llr  = p_llr_q[k*ACC_W +: ACC_W];
    // Read issued while the same row was being written returns stale data; use the written value.
    assign opnd   = p_fwd_q ? p_fwd_dat_q[k*ACC_W +: ACC_W] : i_ram_rd_data[k*ACC_W +: ACC_W];
    assign sum    = {p_llr[ACC_W-1], p_llr} + {opnd[ACC_W-1], opnd};
    assign wr_dat[k*ACC_W +: ACC_W] = !p_cmb_q       ? p_llr   :
                                      (sum > SUM_MAX) ? ACC_MAX :
                                      (sum < SUM_MIN) ? ACC_MIN : sum[ACC_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rows_d      = rows_q;
    buf_d       = buf_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    p_vld_d     = 1'b0;
    p_cmb_d     = 1'b0;
    p_fwd_d     = 1'b0;
    p_addr_d    = p_addr_q;
    p_llr_d     = p_llr_q;
    p_fwd_dat_d = p_fwd_dat_q;
    o_llr_ready = 1'b0;
    o_harq_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (r_bad) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            rows_d  = RW'(r_calc);
            buf_d   = i_buf_sel;
            ptr_d   = '0;
            state_d = S_FILL;
          end
        end
      end
      S_FILL, S_COMBINE: begin
        o_llr_ready = 1'b1;
        if (i_llr_valid) begin
          p_vld_d     = 1'b1;
          p_cmb_d     = (state_q == S_COMBINE);
          p_addr_d    = ptr_q;
          p_llr_d     = llr_ext;
          p_fwd_d     = p_vld_q && (p_addr_q == ptr_q);
          p_fwd_dat_d = wr_dat;
          if (i_llr_last) begin
            state_d = S_FLUSH;
          end else if (ptr_wrap) begin
            ptr_d   = '0;
            state_d = S_COMBINE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
          end
        end
      end
      S_FLUSH: state_d = S_HANDOFF;
      S_HANDOFF: begin
        o_harq_req = 1'b1;
        if (i_harq_ack) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q <= S_IDLE;   ptr_q <= '0;   rows_q <= '0;   buf_q <= 1'b0;
      done_q <= 1'b0;      err_q <= 1'b0;
      p_vld_q <= 1'b0;     p_cmb_q <= 1'b0;   p_fwd_q <= 1'b0;
      p_addr_q <= '0;      p_llr_q <= '0;     p_fwd_dat_q <= '0;
    end else if (i_fsm_clr) begin
      state_q <= S_IDLE;   ptr_q <= '0;   rows_q <= '0;   buf_q <= 1'b0;
      done_q <= 1'b0;      err_q <= 1'b0;
      p_vld_q <= 1'b0;     p_cmb_q <= 1'b0;   p_fwd_q <= 1'b0;
      p_addr_q <= '0;      p_llr_q <= '0;     p_fwd_dat_q <= '0;
    end else begin
      state_q <= state_d;  ptr_q <= ptr_d;  rows_q <= rows_d;  buf_q <= buf_d;
      done_q <= done_d;    err_q <= err_d;
      p_vld_q <= p_vld_d;  p_cmb_q <= p_cmb_d;  p_fwd_q <= p_fwd_d;
      p_addr_q <= p_addr_d; p_llr_q <= p_llr_d; p_fwd_dat_q <= p_fwd_dat_d;
    end
  end

  assign o_ram_rd_addr = ptr_q;
  assign o_ram_rd_sel  = buf_q;
  assign o_ram_wr_en   = p_vld_q;
  assign o_ram_wr_sel  = buf_q;
  assign o_ram_wr_addr = p_addr_q;
  assign o_ram_wr_data = wr_dat;
  assign o_harq_buf    = (state_q == S_HANDOFF) && buf_q;
  assign o_harq_rows   = rows_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_busy        = (state_q != S_IDLE);

endmodule

// File: doc/harq_soft_combine_engine.md
Name: harq_soft_combine_engine

Overview:
Parametrised successor of the single-configuration combine FSM. It accepts rows of LANES soft LLRs from the rate-dematching stage. The first pass over Ncb writes the rows into the selected ping/pong combine buffer. Every wrapped pass read-modify-writes with saturating accumulation. On completion it hands the buffer to the HARQ send stage and waits for its acknowledge.

Parameters:
LANES, 16, LLRs per row; power of two, >=2
LLR_W, 6, signed input LLR width
ACC_W, 10, signed accumulator/buffer width per lane; > LLR_W
ADDR_W, 11, buffer row address width
NUM_USERS, 8, users in packed Ncb vector
NCB_W, 16, per-user Ncb width

Ports:
i_core_clk  in  1  clock
i_rx_rstn  in  1  asynchronous active-low reset
i_fsm_clr  in  1  synchronous abort to IDLE
i_start  in  1  start request, sampled in IDLE
i_user_index  in  $clog2(NUM_USERS)  user select, latched at start
i_users_ncb  in  NUM_USERS*NCB_W  packed Ncb; user u at [u*NCB_W +: NCB_W]
i_buf_sel  in  1  0=ping,1=pong; latched at start
i_llr_valid  in  1  input row valid
o_llr_ready  out  1  input row ready
i_llr_data  in  LANES*LLR_W  signed LLRs; lane k at [k*LLR_W +: LLR_W]
i_llr_last  in  1  last row of the code block
o_ram_rd_addr  out  ADDR_W  buffer read address
o_ram_rd_sel  out  1  ping/pong select for read
i_ram_rd_data  in  LANES*ACC_W  read data, 1-cycle latency
o_ram_wr_en  out  1  buffer write enable
o_ram_wr_sel  out  1  ping/pong select for write
o_ram_wr_addr  out  ADDR_W  write address
o_ram_wr_data  out  LANES*ACC_W  write data
o_harq_req  out  1  buffer ready for HARQ send
o_harq_buf  out  1  buffer select handed to send stage
o_harq_rows  out  ADDR_W+1  valid row count R
i_harq_ack  in  1  send stage accepted request
o_done  out  1  one-cycle completion pulse
o_err  out  1  one-cycle pulse when the latched Ncb yields R==0 or R > 2^ADDR_W
o_busy  out  1  not IDLE

Behaviour:
- All outputs reset to 0. All state, pointers and pass counters reset to 0. Reset is asynchronous at any point and kills any write in flight. i_fsm_clr has the same effect one clock later.
- R = ceil(Ncb/LANES), computed from the Ncb latched at start. Row pointer runs 0..R-1 and wraps to 0.
- States: IDLE, FILL, COMBINE, FLUSH, HANDOFF.
- IDLE: on i_start, latch user, buffer select and R, and go to FILL. If R is invalid, pulse o_err and o_done and stay in IDLE.
- FILL and COMBINE: o_llr_ready=1. A beat is a cycle with valid&ready.
- FILL beat: write sign-extended LLRs at pointer, then advance the pointer.
- COMBINE beat at cycle t: o_ram_rd_addr=pointer in cycle t. At t+1, write sat(sext(llr)+rd_data) per lane to the same address.
- The beat that wraps the pointer R-1->0 in FILL moves the state to COMBINE. Beats continue back-to-back.
- Saturation is symmetric: the result is clamped to +/-(2^(ACC_W-1)-1).
- Input LLR -2^(LLR_W-1) is clamped to -(2^(LLR_W-1)-1) before sign-extension, in both FILL and COMBINE.
- Forwarding: if a COMBINE read targets the address being written in the same cycle (R==1, or a consecutive wrap), the combine operand is the forwarded write data, not i_ram_rd_data.
- A beat with i_llr_last=1 goes to FLUSH and drops o_llr_ready. FLUSH lasts 1 cycle, allowing the final write. Then go to HANDOFF.
- If the last beat is in FILL before the wrap, rows >= pointer stay unwritten. o_harq_rows still reports R; the send stage owns that case.
- HANDOFF: o_harq_req=1 and o_harq_buf=latched select until i_harq_ack. The cycle after ack, pulse o_done and return to IDLE.
- An i_harq_ack received outside HANDOFF is ignored.
- i_start outside IDLE is ignored.
- o_ram_rd_sel and o_ram_wr_sel equal the latched buffer select.
- Writes never target the opposite buffer, so the send stage may read the other buffer concurrently.
- Throughput: 1 row/cycle sustained, no bubbles at the FILL->COMBINE transition.

Test Plan:
- Ncb=64, LANES=16 (R=4), 4 rows of all +5, last on row 3 -> 4 writes of lane value +5, o_harq_rows=4, o_done 1 cycle after ack, FSM reaches IDLE.
- Ncb=64, 8 rows: rows 0-3 = +20 per lane, rows 4-7 = +20 -> rows 0-3 read then written as +40, back-to-back, no ready deassertion.
- Saturation: ACC_W=10, 30 passes of +31 on R=2 -> values stick at +511. Repeat with -32 input -> clamped -31 per pass, stick at -511.
- R=1 (Ncb=10): 3 consecutive beats of +7 -> forwarding gives 7, 14, 21. i_ram_rd_data forced to garbage must not affect the result.
- Ncb=0 -> o_err and o_done pulse, no RAM writes. i_start with i_buf_sel=1 -> all wr_sel=1 and o_harq_buf=1.
- Assert i_rx_rstn mid-COMBINE with a write pending -> o_ram_wr_en=0 immediately, all outputs 0. A fresh start behaves as FILL from row 0.
